// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//
// Main sequencer for the multicycle processor. It steps each instruction
// through fetch, decode, execute, memory and writeback, and drives the
// datapath mux selects. It also raises the unconditioned write requests
// (PCS, RegW, MemW, FlagW), which the condition logic later gates with CondEx.
// Instruction and data memory share a single port. Every access on that port
// waits for mem_ready.
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous, active-low; forces FETCH
//   Op[1:0]     in   instr[27:26]
//   Funct[5:0]  in   instr[25:20] = {I, cmd[3:0], S/L}
//   Rd[3:0]     in   instr[15:12]
//   mem_ready   in   memory finished the current access this cycle
//   mem_req     out  memory access active (FETCH, MEMRD, MEMWR)
//   IRWrite     out  load instruction register
//   NextPC      out  write PC+4
//   AdrSrc      out  memory address: 0 = PC, 1 = ALU result
//   ALUSrcA     out  ALU A: 0 = register, 1 = PC
//   ALUSrcB     out  ALU B: 00 = register, 01 = immediate, 10 = constant 4
//   ResultSrc   out  result: 00 = ALUOut, 01 = read data, 10 = ALU result
//   ALUControl  out  00 add, 01 sub, 10 and, 11 orr
//   PCS         out  PC write request (branch, or register write to R15)
//   RegW        out  register write request
//   MemW        out  memory write request
//   FlagW[1:0]  out  flag write enables: [1] = NZ, [0] = CV
//   instr_done  out  pulse in the last state of each instruction
//   illegal     out  pulse in DECODE for Op = 11 or an unsupported cmd
// ---------------------------------------------------------------------------
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  FETCH     | read the instruction at PC, compute PC+4; wait on mem_ready
//  DECODE    | read registers, compute PC+8; branch on Op/Funct
//  MEMADR    | compute the load/store address (base + immediate)
//  MEMRD     | read data memory; wait on mem_ready
//  MEMWB     | write loaded data into Rd
//  MEMWR     | write data memory; MemW is held for every wait cycle
//  EXECUTER  | data-processing ALU operation, register operand
//  EXECUTEI  | data-processing ALU operation, immediate operand
//  ALUWB     | write the ALU result into Rd (not for CMP or unsupported cmd)
//  BRANCH    | write the branch target into PC
// ---------------------------------------------------------------------------
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic       PCS,
    output logic       RegW,
    output logic       MemW,
    output logic [1:0] FlagW,
    output logic       instr_done,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    state_t state;

    // ------------------------------------------------------------------
    // Data-processing instruction decode
    // ------------------------------------------------------------------
    logic [3:0] cmd;
    logic       s_bit;
    logic       is_add;
    logic       is_sub;
    logic       is_and;
    logic       is_orr;
    logic       is_cmp;
    logic       cmd_ok;
    logic       op_illegal;
    logic       rd_is_pc;

    assign cmd    = Funct[4:1];
    assign s_bit  = Funct[0];
    assign is_add = (cmd == 4'b0100);
    assign is_sub = (cmd == 4'b0010);
    assign is_and = (cmd == 4'b0000);
    assign is_orr = (cmd == 4'b1100);
    // CMP exists only to set flags. A CMP without S does nothing useful,
    // so it is treated as unsupported.
    assign is_cmp = (cmd == 4'b1010) && s_bit;
    assign cmd_ok = is_add | is_sub | is_and | is_orr | is_cmp;

    assign op_illegal = (Op == 2'b11);
    assign rd_is_pc   = (Rd == 4'b1111);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (Op)
                        2'b00:   state <= Funct[5] ? S_EXECUTEI : S_EXECUTER;
                        2'b01:   state <= S_MEMADR;
                        2'b10:   state <= S_BRANCH;
                        default: state <= S_FETCH;
                    endcase
                end
                S_MEMADR: begin
                    state <= Funct[0] ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    if (mem_ready) begin
                        state <= S_MEMWB;
                    end
                end
                S_MEMWR: begin
                    if (mem_ready) begin
                        state <= S_FETCH;
                    end
                end
                S_EXECUTER,
                S_EXECUTEI: state <= S_ALUWB;
                S_MEMWB,
                S_ALUWB,
                S_BRANCH:   state <= S_FETCH;
                default:    state <= S_FETCH;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // The outputs follow the state. The exceptions are the mem_ready gating
    // in the memory states, and the Op/Funct-dependent fields in DECODE,
    // EXECUTE and ALUWB. Because the outputs are combinational, an
    // asynchronous reset takes effect on them at once.
    // ------------------------------------------------------------------
    always_comb begin
        mem_req    = 1'b0;
        IRWrite    = 1'b0;
        NextPC     = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 2'b00;
        RegW       = 1'b0;
        MemW       = 1'b0;
        FlagW      = 2'b00;
        instr_done = 1'b0;
        illegal    = 1'b0;

        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                IRWrite   = mem_ready;
                NextPC    = mem_ready;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                // Op = 11 is retired here as a NOP.
                if (op_illegal) begin
                    illegal    = 1'b1;
                    instr_done = 1'b1;
                end else if (Op == 2'b00 && !cmd_ok) begin
                    illegal = 1'b1;
                end
            end
            S_MEMADR: begin
                ALUSrcB    = 2'b01;
                ALUControl = 2'b00;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                RegW       = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_req    = 1'b1;
                AdrSrc     = 1'b1;
                MemW       = 1'b1;
                instr_done = mem_ready;
            end
            S_EXECUTER,
            S_EXECUTEI: begin
                ALUSrcB = (state == S_EXECUTEI) ? 2'b01 : 2'b00;
                if (is_sub || is_cmp) begin
                    ALUControl = 2'b01;
                end else if (is_and) begin
                    ALUControl = 2'b10;
                end else if (is_orr) begin
                    ALUControl = 2'b11;
                end else begin
                    ALUControl = 2'b00;
                end
                FlagW[1] = s_bit;
                FlagW[0] = s_bit && (is_add || is_sub || is_cmp);
            end
            S_ALUWB: begin
                ResultSrc  = 2'b00;
                instr_done = 1'b1;
                RegW       = cmd_ok && !is_cmp;
            end
            S_BRANCH: begin
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                instr_done = 1'b1;
            end
            default: begin
                // Unused encodings leave every output at 0.
            end
        endcase
    end

    // A register write to R15 is a PC write.
    assign PCS = (state == S_BRANCH) || (RegW && rd_is_pc);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       mem_ready;
    logic       mem_req, IRWrite, NextPC, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ALUControl;
    logic       PCS, RegW, MemW;
    logic [1:0] FlagW;
    logic       instr_done, illegal;

    int n_chk  = 0;
    int n_pass = 0;

    multicycle_control_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .IRWrite    (IRWrite),
        .NextPC     (NextPC),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ALUControl (ALUControl),
        .PCS        (PCS),
        .RegW       (RegW),
        .MemW       (MemW),
        .FlagW      (FlagW),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    // All outputs as one vector:
    // {mem_req, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
    //  ALUControl, PCS, RegW, MemW, FlagW, instr_done, illegal}
    logic [17:0] obs;
    assign obs = {mem_req, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                  ALUControl, PCS, RegW, MemW, FlagW, instr_done, illegal};

    function automatic logic [17:0] mk(
        input logic mr, input logic irw, input logic npc, input logic adr,
        input logic sa, input logic [1:0] sb, input logic [1:0] rs,
        input logic [1:0] alu, input logic pcs, input logic rw, input logic mw,
        input logic [1:0] fw, input logic dn, input logic il);
        return {mr, irw, npc, adr, sa, sb, rs, alu, pcs, rw, mw, fw, dn, il};
    endfunction

    // Hand-written expected output vector for each state.
    function automatic logic [17:0] e_fetch(input logic mr);
        return mk(1'b1, mr, mr, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00,
                  1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    endfunction
    function automatic logic [17:0] e_decode(input logic dn, input logic il);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00,
                  1'b0, 1'b0, 1'b0, 2'b00, dn, il);
    endfunction
    function automatic logic [17:0] e_exec(input logic [1:0] sb, input logic [1:0] alu,
                                           input logic [1:0] fw);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, sb, 2'b00, alu,
                  1'b0, 1'b0, 1'b0, fw, 1'b0, 1'b0);
    endfunction
    function automatic logic [17:0] e_aluwb(input logic rw, input logic pcs);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00,
                  pcs, rw, 1'b0, 2'b00, 1'b1, 1'b0);
    endfunction
    function automatic logic [17:0] e_memadr();
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00,
                  1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    endfunction
    function automatic logic [17:0] e_memrd();
        return mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00,
                  1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    endfunction
    function automatic logic [17:0] e_memwb(input logic pcs);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00,
                  pcs, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
    endfunction
    function automatic logic [17:0] e_memwr(input logic mr);
        return mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00,
                  1'b0, 1'b0, 1'b1, 2'b00, mr, 1'b0);
    endfunction
    function automatic logic [17:0] e_branch();
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00,
                  1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    endfunction

    task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: outputs=%b expected=%b", tag, got, exp);
        end
    endtask

    // One clock cycle: drive mem_ready at the falling edge, check the
    // outputs of the current state, and let the next rising edge advance.
    task automatic cyc(input string tag, input logic mr, input logic [17:0] exp);
        @(negedge clk);
        mem_ready = mr;
        #1;
        chk(tag, obs, exp);
    endtask

    task automatic instr(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd);
        Op    = op;
        Funct = f;
        Rd    = rd;
    endtask

    initial begin
        reset     = 1'b0;
        mem_ready = 1'b0;
        instr(2'b00, 6'b000000, 4'h0);

        // Reset holds FETCH for several cycles, even with mem_ready high.
        cyc("rst_c1", 1'b0, e_fetch(1'b0));
        cyc("rst_c2", 1'b0, e_fetch(1'b0));
        cyc("rst_mr", 1'b1, e_fetch(1'b1));
        cyc("rst_c3", 1'b0, e_fetch(1'b0));
        @(negedge clk);
        reset = 1'b1;

        // ADDS R1, register operand.
        instr(2'b00, 6'b001001, 4'h1);
        cyc("adds_fetch", 1'b1, e_fetch(1'b1));
        cyc("adds_dec",   1'b0, e_decode(1'b0, 1'b0));
        cyc("adds_exe",   1'b1, e_exec(2'b00, 2'b00, 2'b11));
        cyc("adds_wb",    1'b0, e_aluwb(1'b1, 1'b0));

        // CMP: sets flags and writes no register.
        instr(2'b00, 6'b010101, 4'h0);
        cyc("cmp_fetch", 1'b1, e_fetch(1'b1));
        cyc("cmp_dec",   1'b1, e_decode(1'b0, 1'b0));
        cyc("cmp_exe",   1'b0, e_exec(2'b00, 2'b01, 2'b11));
        cyc("cmp_wb",    1'b0, e_aluwb(1'b0, 1'b0));

        // ORR to R15: this register write becomes a PC write.
        instr(2'b00, 6'b011000, 4'hF);
        cyc("orr_fetch", 1'b1, e_fetch(1'b1));
        cyc("orr_dec",   1'b0, e_decode(1'b0, 1'b0));
        cyc("orr_exe",   1'b0, e_exec(2'b00, 2'b11, 2'b00));
        cyc("orr_wb",    1'b0, e_aluwb(1'b1, 1'b1));

        // SUBS immediate after one fetch wait cycle.
        instr(2'b00, 6'b100101, 4'h2);
        cyc("subi_fwait", 1'b0, e_fetch(1'b0));
        cyc("subi_fetch", 1'b1, e_fetch(1'b1));
        cyc("subi_dec",   1'b0, e_decode(1'b0, 1'b0));
        cyc("subi_exe",   1'b0, e_exec(2'b01, 2'b01, 2'b11));
        cyc("subi_wb",    1'b0, e_aluwb(1'b1, 1'b0));

        // ANDS immediate: logic op updates NZ only.
        instr(2'b00, 6'b100001, 4'h5);
        cyc("andi_fetch", 1'b1, e_fetch(1'b1));
        cyc("andi_dec",   1'b0, e_decode(1'b0, 1'b0));
        cyc("andi_exe",   1'b0, e_exec(2'b01, 2'b10, 2'b10));
        cyc("andi_wb",    1'b0, e_aluwb(1'b1, 1'b0));

        // Unsupported cmd 0011: illegal pulse and no register write.
        instr(2'b00, 6'b000110, 4'h3);
        cyc("bad_fetch", 1'b1, e_fetch(1'b1));
        cyc("bad_dec",   1'b0, e_decode(1'b0, 1'b1));
        cyc("bad_exe",   1'b0, e_exec(2'b00, 2'b00, 2'b00));
        cyc("bad_wb",    1'b0, e_aluwb(1'b0, 1'b0));

        // CMP without S is unsupported.
        instr(2'b00, 6'b010100, 4'h0);
        cyc("cmpns_fetch", 1'b1, e_fetch(1'b1));
        cyc("cmpns_dec",   1'b0, e_decode(1'b0, 1'b1));
        cyc("cmpns_exe",   1'b0, e_exec(2'b00, 2'b00, 2'b00));
        cyc("cmpns_wb",    1'b0, e_aluwb(1'b0, 1'b0));

        // LDR with two MEMRD wait cycles: 7 cycles in total.
        instr(2'b01, 6'b011001, 4'h4);
        cyc("ldr_fetch", 1'b1, e_fetch(1'b1));
        cyc("ldr_dec",   1'b0, e_decode(1'b0, 1'b0));
        cyc("ldr_adr",   1'b1, e_memadr());
        cyc("ldr_rd_w1", 1'b0, e_memrd());
        cyc("ldr_rd_w2", 1'b0, e_memrd());
        cyc("ldr_rd",    1'b1, e_memrd());
        cyc("ldr_wb",    1'b0, e_memwb(1'b0));

        // LDR into R15 with no waits: the load write becomes a PC write.
        instr(2'b01, 6'b011001, 4'hF);
        cyc("ldpc_fetch", 1'b1, e_fetch(1'b1));
        cyc("ldpc_dec",   1'b0, e_decode(1'b0, 1'b0));
        cyc("ldpc_adr",   1'b0, e_memadr());
        cyc("ldpc_rd",    1'b1, e_memrd());
        cyc("ldpc_wb",    1'b1, e_memwb(1'b1));

        // STR with one wait: MemW on for two cycles, instr_done only in the second.
        instr(2'b01, 6'b011000, 4'h6);
        cyc("str_fetch", 1'b1, e_fetch(1'b1));
        cyc("str_dec",   1'b0, e_decode(1'b0, 1'b0));
        cyc("str_adr",   1'b0, e_memadr());
        cyc("str_wr_w",  1'b0, e_memwr(1'b0));
        cyc("str_wr",    1'b1, e_memwr(1'b1));

        // Branch.
        instr(2'b10, 6'b000000, 4'h0);
        cyc("b_fetch",  1'b1, e_fetch(1'b1));
        cyc("b_dec",    1'b0, e_decode(1'b0, 1'b0));
        cyc("b_branch", 1'b0, e_branch());

        // Op = 11: retired as a NOP in DECODE.
        instr(2'b11, 6'b000000, 4'h0);
        cyc("op11_fetch", 1'b1, e_fetch(1'b1));
        cyc("op11_dec",   1'b0, e_decode(1'b1, 1'b1));
        cyc("op11_back",  1'b0, e_fetch(1'b0));

        // Reset during a MEMWR wait: MemW drops at once, with no clock edge.
        instr(2'b01, 6'b000000, 4'h7);
        cyc("rstw_fetch", 1'b1, e_fetch(1'b1));
        cyc("rstw_dec",   1'b0, e_decode(1'b0, 1'b0));
        cyc("rstw_adr",   1'b0, e_memadr());
        cyc("rstw_wr",    1'b0, e_memwr(1'b0));
        #2;
        reset = 1'b0;
        #1;
        chk("rstw_async", obs, e_fetch(1'b0));
        cyc("rstw_hold", 1'b0, e_fetch(1'b0));
        @(negedge clk);
        reset = 1'b1;

        // Normal operation resumes after reset is released.
        instr(2'b10, 6'b000000, 4'h0);
        cyc("post_fetch",  1'b1, e_fetch(1'b1));
        cyc("post_dec",    1'b0, e_decode(1'b0, 1'b0));
        cyc("post_branch", 1'b0, e_branch());
        cyc("post_idle",   1'b0, e_fetch(1'b0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
